// File: rtl/adc_packet_framer_pkg.sv
// Shared definitions for the ADC packet framer: FSM encoding, default sync byte,
// packet field order (host decoders use the same order) and checksum helper.
package adc_packet_framer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SYNC      = 3'd1,
        ST_SEQ       = 3'd2,
        ST_LEN       = 3'd3,
        ST_FETCH     = 3'd4,
        ST_WAIT_DATA = 3'd5,
        ST_DATA      = 3'd6,
        ST_CSUM      = 3'd7
    } state_t;

    localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;

    // Byte offsets within a packet; checksum follows the last payload byte.
    localparam int FLD_SYNC    = 0;
    localparam int FLD_SEQ     = 1;
    localparam int FLD_LEN     = 2;
    localparam int FLD_PAYLOAD = 3;

    function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction

endpackage

// File: rtl/adc_packet_framer_if.sv
// Framer-side bus bundle: control, capture FIFO read port and UART TX byte stream.
interface adc_packet_framer_if;
    logic       enable;
    logic [7:0] fifo_data;
    logic       fifo_data_ready;
    logic       fifo_read_enable;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       packet_done;

    modport master (
        input  enable, fifo_data, fifo_data_ready, tx_ready,
        output fifo_read_enable, tx_data, tx_valid, busy, packet_done
    );

    modport slave (
        output enable, fifo_data, fifo_data_ready, tx_ready,
        input  fifo_read_enable, tx_data, tx_valid, busy, packet_done
    );
endinterface

// File: rtl/adc_packet_framer_tx_byte_reg.sv
// Output holding register: byte + valid, loaded by the FSM, cleared on accept.
// Contents never change while valid is waiting for ready.
module tx_byte_reg (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_load,
    input  logic [7:0] i_data,
    input  logic       i_ready,
    output logic [7:0] o_data,
    output logic       o_valid
);
    logic [7:0] r_data;
    logic       r_valid;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_data  <= 8'h00;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_data  <= i_data;
            r_valid <= 1'b1;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;
endmodule

// File: rtl/adc_packet_framer.sv
// Wraps each run of PAYLOAD_LEN FIFO bytes as SYNC, SEQ, LEN, payload, CHECKSUM
// on a valid/ready byte stream. FSM, counters and checksum live here.
module adc_packet_framer
    import adc_packet_framer_pkg::*;
#(
    parameter int         PAYLOAD_LEN = 64,
    parameter logic [7:0] SYNC_BYTE   = DEF_SYNC_BYTE
) (
    input logic                  i_clk,
    input logic                  i_rst,
    adc_packet_framer_if.master  bus
);
    localparam logic [7:0] C_LEN = 8'(PAYLOAD_LEN);

    state_t     r_state, w_next;
    logic [7:0] r_seq, r_csum, r_cnt;
    logic       w_load, w_pop, w_accept, w_tx_valid;
    logic [7:0] w_load_data, w_tx_data, w_cnt_next;

    assign w_accept   = w_tx_valid & bus.tx_ready;
    assign w_cnt_next = r_cnt + 8'd1;

    always_comb begin
        w_next      = r_state;
        w_load      = 1'b0;
        w_load_data = 8'h00;
        w_pop       = 1'b0;
        case (r_state)
            ST_IDLE: if (bus.enable && bus.fifo_data_ready) begin
                w_next      = ST_SYNC;
                w_load      = 1'b1;
                w_load_data = SYNC_BYTE;
            end
            ST_SYNC: if (w_accept) begin
                w_next      = ST_SEQ;
                w_load      = 1'b1;
                w_load_data = r_seq;
            end
            ST_SEQ: if (w_accept) begin
                w_next      = ST_LEN;
                w_load      = 1'b1;
                w_load_data = C_LEN;
            end
            ST_LEN: if (w_accept) w_next = ST_FETCH;
            ST_FETCH: if (bus.fifo_data_ready) begin
                w_pop  = 1'b1;
                w_next = ST_WAIT_DATA;
            end
            ST_WAIT_DATA: begin
                w_load      = 1'b1;
                w_load_data = bus.fifo_data;
                w_next      = ST_DATA;
            end
            ST_DATA: if (w_accept) begin
                if (w_cnt_next == C_LEN) begin
                    // Checksum must include the payload byte being accepted now.
                    w_next      = ST_CSUM;
                    w_load      = 1'b1;
                    w_load_data = csum_add(r_csum, w_tx_data);
                end else begin
                    w_next = ST_FETCH;
                end
            end
            ST_CSUM: if (w_accept) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_seq  <= 8'h00;
            r_csum <= 8'h00;
            r_cnt  <= 8'h00;
        end else if (w_accept) begin
            case (r_state)
                ST_SEQ, ST_LEN: r_csum <= csum_add(r_csum, w_tx_data);
                ST_DATA: begin
                    r_csum <= csum_add(r_csum, w_tx_data);
                    r_cnt  <= w_cnt_next;
                end
                ST_CSUM: begin
                    r_csum <= 8'h00;
                    r_cnt  <= 8'h00;
                    r_seq  <= r_seq + 8'd1;
                end
                default: ;
            endcase
        end
    end

    tx_byte_reg u_tx_reg (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_load  (w_load),
        .i_data  (w_load_data),
        .i_ready (bus.tx_ready),
        .o_data  (w_tx_data),
        .o_valid (w_tx_valid)
    );

    assign bus.tx_data          = w_tx_data;
    assign bus.tx_valid         = w_tx_valid;
    assign bus.fifo_read_enable = w_pop;
    assign bus.busy             = (r_state != ST_IDLE);
    assign bus.packet_done      = (r_state == ST_CSUM) && w_accept;
endmodule

// File: tb/tb_adc_packet_framer.sv
// Scoreboard bench for adc_packet_framer with PAYLOAD_LEN=4: expected bytes are
// queued at stimulus time and popped by a monitor on every accepted TX byte.
module tb_adc_packet_framer;
    typedef struct { logic [7:0] d; bit last; } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    adc_packet_framer_if bus();

    adc_packet_framer #(.PAYLOAD_LEN(4), .SYNC_BYTE(8'hA5)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    // Capture FIFO model: data appears one cycle after the pop strobe.
    logic [7:0] mem [0:2047];
    int f_wr = 0;
    int f_rd = 0;
    assign bus.fifo_data_ready = (f_wr != f_rd);
    initial bus.fifo_data = 8'h00;
    always @(posedge clk) begin
        if (!rst && bus.fifo_read_enable && (f_wr != f_rd)) begin
            bus.fifo_data <= mem[f_rd % 2048];
            f_rd <= f_rd + 1;
        end
    end

    // TX sink: ready always high, or held low 5 cycles on each new byte.
    bit stall_mode = 1'b0;
    int st_cnt = 0;
    initial bus.tx_ready = 1'b0;
    always @(posedge clk) begin
        #1;
        if (!stall_mode) begin
            bus.tx_ready = 1'b1;
        end else if (bus.tx_valid && st_cnt < 5) begin
            bus.tx_ready = 1'b0;
            st_cnt++;
        end else if (bus.tx_valid) begin
            bus.tx_ready = 1'b1;
            st_cnt = 0;
        end else begin
            bus.tx_ready = 1'b0;
            st_cnt = 0;
        end
    end

    exp_t exp_q[$];
    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    logic [7:0] m_seq = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic push_exp(input logic [3:0][7:0] p, input logic [7:0] cs);
        exp_q.push_back('{8'hA5, 1'b0});
        exp_q.push_back('{m_seq, 1'b0});
        exp_q.push_back('{8'h04, 1'b0});
        for (int i = 3; i >= 0; i--) exp_q.push_back('{p[i], 1'b0});
        exp_q.push_back('{cs, 1'b1});
        m_seq = m_seq + 8'd1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        mem[f_wr % 2048] = b;
        f_wr = f_wr + 1;
    endtask

    task automatic push_fifo(input logic [3:0][7:0] p);
        for (int i = 3; i >= 0; i--) push_byte(p[i]);
    endtask

    task automatic wait_done(input string name);
        int target;
        bit ok;
        target = done_cnt + 1;
        ok = 1'b0;
        for (int c = 0; c < 600 && !ok; c++) begin
            @(negedge clk);
            if (done_cnt >= target) ok = 1'b1;
        end
        chk({name, "_done_timeout"}, {31'd0, ok}, 32'd1);
    endtask

    initial begin
        logic [3:0][7:0] p;
        logic [7:0] cs;
        int base;
        bit ok;

        bus.enable = 1'b0;

        fork
            begin : monitor
                bit         hold = 1'b0;
                bit         fre_d = 1'b0;
                logic [7:0] hdata = 8'h00;
                exp_t       e;
                forever begin
                    @(negedge clk);
                    if (rst) begin
                        hold  = 1'b0;
                        fre_d = 1'b0;
                    end else begin
                        if (hold) begin
                            chk("hold_valid", {31'd0, bus.tx_valid}, 32'd1);
                            chk("hold_data", {24'd0, bus.tx_data}, {24'd0, hdata});
                        end
                        if (bus.fifo_read_enable) begin
                            if (fre_d) chk("pop_back_to_back", 32'd1, 32'd0);
                            if (!bus.fifo_data_ready) chk("pop_when_empty", 32'd1, 32'd0);
                        end
                        if (bus.tx_valid && bus.tx_ready) begin
                            if (exp_q.size() == 0) begin
                                chk("unexpected_byte", {24'd0, bus.tx_data}, 32'hFFFF_FFFF);
                            end else begin
                                e = exp_q.pop_front();
                                chk("tx_byte", {24'd0, bus.tx_data}, {24'd0, e.d});
                                chk("packet_done", {31'd0, bus.packet_done}, {31'd0, e.last});
                                if (bus.packet_done) done_cnt++;
                            end
                        end else if (bus.packet_done) begin
                            chk("spurious_done", 32'd1, 32'd0);
                        end
                        hold  = bus.tx_valid && !bus.tx_ready;
                        hdata = bus.tx_data;
                        fre_d = bus.fifo_read_enable;
                    end
                end
            end
        join_none

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_tx_valid", {31'd0, bus.tx_valid}, 32'd0);
        chk("rst_tx_data", {24'd0, bus.tx_data}, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_fre", {31'd0, bus.fifo_read_enable}, 32'd0);
        chk("rst_done", {31'd0, bus.packet_done}, 32'd0);
        rst = 1'b0;
        bus.enable = 1'b1;

        // 1: basic packet, checksum 00+04+00+01+02+03
        base = f_rd;
        push_exp({8'h00, 8'h01, 8'h02, 8'h03}, 8'h0A);
        push_fifo({8'h00, 8'h01, 8'h02, 8'h03});
        wait_done("p1");
        chk("p1_pops", f_rd - base, 32'd4);

        // 2: SEQ=1, checksum 01+04+10+11+12+13
        push_exp({8'h10, 8'h11, 8'h12, 8'h13}, 8'h4B);
        push_fifo({8'h10, 8'h11, 8'h12, 8'h13});
        wait_done("p2");

        // 3: 5-cycle backpressure per byte, SEQ=2
        stall_mode = 1'b1;
        push_exp({8'h00, 8'h01, 8'h02, 8'h03}, 8'h0C);
        push_fifo({8'h00, 8'h01, 8'h02, 8'h03});
        wait_done("p3");
        stall_mode = 1'b0;

        // 4: FIFO runs dry after two payload bytes, SEQ=3
        base = f_rd;
        push_exp({8'h20, 8'h21, 8'h22, 8'h23}, 8'h8D);
        push_byte(8'h20);
        push_byte(8'h21);
        ok = 1'b0;
        for (int c = 0; c < 200 && !ok; c++) begin
            @(negedge clk);
            if (f_rd - base == 2) ok = 1'b1;
        end
        chk("p4_two_pops_timeout", {31'd0, ok}, 32'd1);
        repeat (3) @(negedge clk);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (c % 5 == 0) begin
                chk("stall_fre", {31'd0, bus.fifo_read_enable}, 32'd0);
                chk("stall_tx_valid", {31'd0, bus.tx_valid}, 32'd0);
                chk("stall_busy", {31'd0, bus.busy}, 32'd1);
            end
        end
        push_byte(8'h22);
        push_byte(8'h23);
        wait_done("p4");
        chk("p4_pops", f_rd - base, 32'd4);

        // 5: reset after the second payload byte of SEQ=4
        push_exp({8'h30, 8'h31, 8'h32, 8'h33}, 8'h00);
        push_fifo({8'h30, 8'h31, 8'h32, 8'h33});
        ok = 1'b0;
        for (int c = 0; c < 200 && !ok; c++) begin
            @(negedge clk);
            if (exp_q.size() == 3) ok = 1'b1;
        end
        chk("p5_progress_timeout", {31'd0, ok}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_tx_valid", {31'd0, bus.tx_valid}, 32'd0);
        chk("mid_rst_tx_data", {24'd0, bus.tx_data}, 32'd0);
        chk("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("mid_rst_fre", {31'd0, bus.fifo_read_enable}, 32'd0);
        exp_q.delete();
        f_wr = f_rd;
        m_seq = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        push_exp({8'h40, 8'h41, 8'h42, 8'h43}, 8'h0A);
        push_fifo({8'h40, 8'h41, 8'h42, 8'h43});
        wait_done("p5_after_rst");

        // 6a: Enable low in IDLE with data waiting -> nothing starts
        bus.enable = 1'b0;
        push_fifo({8'h50, 8'h51, 8'h52, 8'h53});
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c % 3 == 0) begin
                chk("en_low_busy", {31'd0, bus.busy}, 32'd0);
                chk("en_low_tx_valid", {31'd0, bus.tx_valid}, 32'd0);
            end
        end
        push_exp({8'h50, 8'h51, 8'h52, 8'h53}, 8'h4B);
        bus.enable = 1'b1;
        wait_done("p6_first");

        // 6b: run SEQ through 255 and wrap to 0
        for (int k = 0; k < 255; k++) begin
            p = {8'(k), 8'(k + 3), 8'(k ^ 8'h5A), 8'hC3};
            cs = m_seq + 8'h04 + p[3] + p[2] + p[1] + p[0];
            push_exp(p, cs);
            push_fifo(p);
            wait_done("seq_run");
        end

        repeat (3) @(negedge clk);
        chk("final_queue_empty", exp_q.size(), 32'd0);
        chk("final_busy", {31'd0, bus.busy}, 32'd0);
        chk("final_seq_model", {24'd0, m_seq}, 32'd1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
